// File: rtl/debounce_sync.sv
// Debouncer: multi-flop synchronizer, stability-count FSM, registered level and edge pulses.
// Optional macro DEBOUNCE_EDGE_EN builds the rise/fall pulse registers; otherwise both ports are tied low.
module debounce_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 50000,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE_LO,
        WAIT_HI,
        IDLE_HI,
        WAIT_LO
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   dout_q;
    logic                   busy_q;
    logic                   qual_hi;
    logic                   qual_lo;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], din};
    assign s      = sync_q[SYNC_STAGES-1];

    // NOTE: reset is asynchronous and active-low, so every flop clears the moment reset drops, not at the next edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    // A candidate level qualifies on the edge that sees its STABLE_CNT-th consecutive sample.
    assign qual_hi = (state_q == WAIT_HI) && s  && (cnt_q == CNT_LAST);
    assign qual_lo = (state_q == WAIT_LO) && !s && (cnt_q == CNT_LAST);

    // NOTE: non-blocking assignments keep every register in this block reading pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE_LO;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE_LO: begin
                    if (s) begin
                        state_q <= WAIT_HI;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!s) begin
                        state_q <= IDLE_LO;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (qual_hi) begin
                        state_q <= IDLE_HI;
                        cnt_q   <= '0;
                        dout_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                IDLE_HI: begin
                    if (!s) begin
                        state_q <= WAIT_LO;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                WAIT_LO: begin
                    if (s) begin
                        state_q <= IDLE_HI;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (qual_lo) begin
                        state_q <= IDLE_LO;
                        cnt_q   <= '0;
                        dout_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign dout = dout_q;
    assign busy = busy_q;

`ifdef DEBOUNCE_EDGE_EN
    logic rise_q;
    logic fall_q;

    // Pulses land on the same edge that updates dout, so they line up with its new value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= qual_hi;
            fall_q <= qual_lo;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

    a_edge_excl: assert property (@(posedge clk) disable iff (!reset) !(rise_q && fall_q));
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

    a_cnt_bound: assert property (@(posedge clk) disable iff (!reset) cnt_q <= CNT_LAST);
    a_busy_state: assert property (@(posedge clk) disable iff (!reset)
                                   busy_q == ((state_q == WAIT_HI) || (state_q == WAIT_LO)));

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync: a run-length reference model queues expected outputs per edge, a monitor checks them.
module tb_debounce_sync;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int CW     = 3;
`ifdef DEBOUNCE_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    typedef struct packed {
        logic dout;
        logic rise;
        logic fall;
        logic busy;
    } resp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic din   = 1'b0;
    logic dout, rise, fall, busy;

    resp_t exp_q[$];
    bit    hist[$];
    bit    m_dout;
    int    m_run;
    int    n_checks = 0;
    int    n_fail   = 0;

    debounce_sync #(
        .SYNC_STAGES(SYNC),
        .STABLE_CNT (STABLE),
        .CNT_W      (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .din  (din),
        .dout (dout),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: s is din from SYNC edges ago; a run of STABLE samples differing from dout flips it.
    task automatic model_edge();
        resp_t r;
        bit    s;
        r = '0;
        if (!reset) begin
            hist.delete();
            m_dout = 1'b0;
            m_run  = 0;
        end else begin
            s = (hist.size() >= SYNC) ? hist[SYNC-1] : 1'b0;
            hist.push_front(din);
            if (hist.size() > SYNC) void'(hist.pop_back());
            if (s != m_dout) begin
                m_run++;
                if (m_run == STABLE) begin
                    m_dout = s;
                    r.rise = EDGE && s;
                    r.fall = EDGE && !s;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
            r.dout = m_dout;
            r.busy = (m_run != 0);
        end
        exp_q.push_back(r);
    endtask

    task automatic tick(input bit d, input bit r);
        din   = d;
        reset = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic mid_cycle_reset(input string tag);
        reset = 1'b0;
        #1;
        check({tag, "_dout"}, dout, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_rise"}, rise, 1'b0);
        check({tag, "_fall"}, fall, 1'b0);
    endtask

    always @(negedge clk) begin
        resp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_dout", dout, e.dout);
            check("sb_rise", rise, e.rise);
            check("sb_fall", fall, e.fall);
            check("sb_busy", busy, e.busy);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        bit lvl;
        @(negedge clk);
        #1;

        // Reset held with din high: all outputs stay low.
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
        check("rst_dout", dout, 1'b0);
        check("rst_busy", busy, 1'b0);

        // Clean rise, short glitch, clean fall.
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1);
        check("rise_level", dout, 1'b1);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1);
        check("fall_level", dout, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1);
        check("glitch_level", dout, 1'b0);

        // Reset in WAIT_HI with cnt=2, then full latency again.
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
        mid_cycle_reset("rst_wait");
        tick(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1);
        check("relatch_level", dout, 1'b1);

        // Reset while dout is high clears it within the cycle.
        mid_cycle_reset("rst_high");
        tick(1'b0, 1'b0);

        // Chatter every two cycles, then a steady high.
        for (int i = 0; i < 40; i++) tick(((i / 2) % 2) == 0, 1'b1);
        check("chatter_level", dout, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1);
        check("hold_level", dout, 1'b1);

        // Random hold lengths straddling the qualification window, rare resets.
        lvl = 1'b0;
        for (int k = 0; k < 120; k++) begin
            lvl  = ~lvl;
            hold = $urandom_range(1, 8);
            for (int i = 0; i < hold; i++) tick(lvl, ($urandom_range(0, 99) != 0));
        end
        for (int i = 0; i < 8; i++) tick(lvl, 1'b1);

        @(negedge clk);
        #1;
        check("sb_drained", exp_q.size() == 0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Conditions a raw asynchronous input into a clean, synchronous level for the D flip-flop stage (dffbhe) downstream. That stage samples `d` on the falling edge, so this block's rising-edge outputs give it half a cycle of margin.
- Chain: multi-flop synchronizer, then a stability counter FSM, then a registered level output and single-cycle edge pulses.
- Typical use: push-buttons and switches feeding the lab flops and counters.

Parameters:
- SYNC_STAGES, 2: synchronizer flops; legal range 2..4.
- STABLE_CNT, 50000: consecutive identical synchronized samples needed before the output changes; minimum 2.
- CNT_W, 16: counter width; must satisfy 2^CNT_W > STABLE_CNT.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- din  input  1  raw asynchronous input; may bounce.
- dout  output  1  debounced, synchronized level; drives `d` of the downstream flop.
- rise  output  1  one-cycle pulse when dout goes 0->1.
- fall  output  1  one-cycle pulse when dout goes 1->0.
- busy  output  1  high while a candidate transition is being qualified.

Behaviour:
- Reset (reset=0), asynchronous and immediate:
  - all synchronizer flops 0, cnt=0, state IDLE_LO;
  - dout=0, rise=0, fall=0, busy=0;
  - held for as long as reset=0, regardless of clk or din.
- Synchronizer: din shifts through SYNC_STAGES flops; the last stage (s) is the only signal the FSM sees.
- States: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO. Encoding is free.
- IDLE_LO:
  - s=1: go to WAIT_HI, cnt<=1.
  - otherwise stay, cnt<=0.
- WAIT_HI:
  - s=0: go to IDLE_LO, cnt<=0, no output change (glitch rejected).
  - s=1 and cnt==STABLE_CNT-1: go to IDLE_HI, dout<=1, rise<=1, cnt<=0.
  - s=1 otherwise: cnt<=cnt+1.
- IDLE_HI and WAIT_LO mirror IDLE_LO and WAIT_HI with polarity inverted. Qualifying a low drives dout<=0 and fall<=1.
- rise and fall are registered. Each is high for exactly one cycle, the same cycle dout first shows its new value. They are never high together.
- busy is 1 exactly when state is WAIT_HI or WAIT_LO.
- Latency: with din held stable from the first edge E1 that samples it, dout changes at edge E(SYNC_STAGES+STABLE_CNT). Defaults give 50002 cycles.
- Partial qualification: any mismatch restarts qualification from zero; progress is never kept.
- Counter: cnt never exceeds STABLE_CNT-1 and cannot wrap.
- Reset mid-qualification: an in-progress count is discarded. After release, a high din requires the full latency again.
- Reset release: the first edge with reset=1 starts normal sampling. No extra settling cycles.

Optional Feature:
- Macro: DEBOUNCE_EDGE_EN.
- Defined: rise and fall behave as above.
- Undefined: the rise/fall registers are not built and both ports are tied to constant 0. dout, busy and latency are unchanged.

Test Plan:
All scenarios use SYNC_STAGES=2, STABLE_CNT=4, DEBOUNCE_EDGE_EN defined.
1. reset=0 with din=1 and clk running for 10 cycles -> dout=0, rise=0, fall=0, busy=0 throughout; reset asserted between edges clears dout within the same cycle.
2. Release reset, din 0->1 held -> busy=1 from edge E3 through E5; dout=1 at E6; rise=1 only in the E6 cycle; busy=0 after E6.
3. din high for 3 cycles then low -> busy pulses, dout stays 0, rise never asserts; cnt returns to 0.
4. From dout=1, din 1->0 held -> dout=0 at E6 after the change, fall=1 for one cycle, rise stays 0.
5. In WAIT_HI with cnt=2, pull reset low mid-cycle -> dout=0 and busy=0 immediately; release with din=1 -> dout rises only after the full 6 edges.
6. din toggles every 2 cycles for 40 cycles, then holds 1 -> no dout change during chatter; dout=1 exactly 6 edges after the hold begins; one rise pulse total.
